// File: rtl/camera_pkg.sv
// camera_pkg: shared definitions for the camera_sync block.
//   H_DEFAULT / V_DEFAULT : default active pixels per line / lines per frame
//   cam_state_t           : frame-tracking FSM states
//   idx_w(n)              : bits needed for an index 0..n-1
//   cnt_w(n)              : bits needed for a count 0..n (room for a saturation marker)
package camera_pkg;

    localparam int unsigned H_DEFAULT = 752;
    localparam int unsigned V_DEFAULT = 480;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_FRAME,
        ST_LINE
    } cam_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle rise/fall pulses from an already-registered level.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_level : registered level to watch
//   o_rise  : high for one cycle when i_level goes 0->1
//   o_fall  : high for one cycle when i_level goes 1->0
module edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;
    assign o_fall = ~i_level & r_prev;

endmodule

// File: rtl/camera_sync.sv
// camera_sync: aligns a parallel image-sensor stream to frame/line/column
// coordinates, with 2-cycle pin-to-output latency and sticky geometry errors.
//   CLK, RST_N            : pixel clock, asynchronous active-low reset
//   FRAME_VALID, LINE_VALID, PIX_IN : sensor pins
//   CLEAR_ERR             : one-cycle pulse clearing both error flags
//   VALID_DATA, DATA_OUT  : in-range active pixel and its value
//   CURRENT_COLUMN/LINE   : coordinates of DATA_OUT, held when not valid
//   FRAME_START, LINE_END, FRAME_END : one-cycle event pulses
//   FRAME_COUNT           : completed frames (wrapping)
//   LINE_LEN_ERR, LINE_CNT_ERR : sticky line-length / line-count errors
module camera_sync
    import camera_pkg::*;
#(
    parameter int unsigned H = H_DEFAULT,
    parameter int unsigned V = V_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                FRAME_VALID,
    input  logic                LINE_VALID,
    input  logic [7:0]          PIX_IN,
    input  logic                CLEAR_ERR,
    output logic                VALID_DATA,
    output logic [7:0]          DATA_OUT,
    output logic [idx_w(H)-1:0] CURRENT_COLUMN,
    output logic [idx_w(V)-1:0] CURRENT_LINE,
    output logic                FRAME_START,
    output logic                LINE_END,
    output logic                FRAME_END,
    output logic [15:0]         FRAME_COUNT,
    output logic                LINE_LEN_ERR,
    output logic                LINE_CNT_ERR
);

    localparam int unsigned CW  = cnt_w(H);
    localparam int unsigned LW  = cnt_w(V);
    localparam int unsigned CIW = idx_w(H);
    localparam int unsigned LIW = idx_w(V);

    localparam logic [CW-1:0] COL_SAT  = CW'(H);
    localparam logic [CW-1:0] COL_LAST = CW'(H - 1);
    localparam logic [LW-1:0] LINE_SAT = LW'(V);

    logic            r_fv_q;
    logic            r_lv_q;
    logic [7:0]      r_pix_q;
    cam_state_t      r_state;
    logic [CW-1:0]   r_col;        // index of the last accepted pixel; H = overflow
    logic [LW-1:0]   r_line;       // completed lines this frame; saturates at V
    logic            r_extra_line; // a line completed while r_line was already V
    logic            r_valid;
    logic [7:0]      r_data;
    logic [CIW-1:0]  r_cur_col;
    logic [LIW-1:0]  r_cur_line;
    logic            r_frame_start;
    logic            r_line_end;
    logic            r_frame_end;
    logic [15:0]     r_frame_count;
    logic            r_len_err;
    logic            r_cnt_err;

    logic            w_fv_rise;
    logic            w_fv_fall;
    logic            w_lv_rise;
    logic            w_lv_fall;
    logic [CW-1:0]   w_col_idx;
    logic [LW-1:0]   w_line_inc;
    logic            w_accept;
    logic            w_pix_ok;

    // r_fv_q resets high so SYNC waits for a genuinely sampled low level;
    // otherwise a release mid-frame would look like a fresh frame start.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fv_q  <= 1'b1;
            r_lv_q  <= 1'b0;
            r_pix_q <= '0;
        end else begin
            r_fv_q  <= FRAME_VALID;
            r_lv_q  <= LINE_VALID;
            r_pix_q <= PIX_IN;
        end
    end

    edge_detect u_fv_edge (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_level (r_fv_q),
        .o_rise  (w_fv_rise),
        .o_fall  (w_fv_fall)
    );

    edge_detect u_lv_edge (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_level (r_lv_q),
        .o_rise  (w_lv_rise),
        .o_fall  (w_lv_fall)
    );

    // A line is entered on the LINE_VALID rising edge, so a line already in
    // progress when the frame opens is treated as partial and skipped.
    always_comb begin
        w_col_idx = '0;
        if (r_state == ST_LINE) begin
            w_col_idx = (r_col == COL_SAT) ? COL_SAT : r_col + CW'(1);
        end
        w_line_inc = (r_line == LINE_SAT) ? LINE_SAT : r_line + LW'(1);
        w_accept   = !w_fv_fall &&
                     (((r_state == ST_FRAME) && w_lv_rise) ||
                      ((r_state == ST_LINE) && r_lv_q));
        w_pix_ok   = (w_col_idx != COL_SAT) && (r_line != LINE_SAT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_SYNC;
            r_col         <= '0;
            r_line        <= '0;
            r_extra_line  <= 1'b0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_cur_col     <= '0;
            r_cur_line    <= '0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_count <= '0;
            r_len_err     <= 1'b0;
            r_cnt_err     <= 1'b0;
        end else begin
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;

            // Error sets below are later in the block, so they win over a clear.
            if (CLEAR_ERR) begin
                r_len_err <= 1'b0;
                r_cnt_err <= 1'b0;
            end

            if (w_accept) begin
                r_col <= w_col_idx;
                if (w_pix_ok) begin
                    r_valid    <= 1'b1;
                    r_data     <= r_pix_q;
                    r_cur_col  <= w_col_idx[CIW-1:0];
                    r_cur_line <= r_line[LIW-1:0];
                end
            end

            case (r_state)
                ST_SYNC: begin
                    if (!r_fv_q) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_fv_rise) begin
                        r_state       <= ST_FRAME;
                        r_frame_start <= 1'b1;
                        r_line        <= '0;
                        r_extra_line  <= 1'b0;
                        r_col         <= '0;
                    end
                end
                ST_FRAME: begin
                    if (w_fv_fall) begin
                        r_state       <= ST_IDLE;
                        r_frame_end   <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                        if ((r_line != LINE_SAT) || r_extra_line) r_cnt_err <= 1'b1;
                    end else if (w_lv_rise) begin
                        r_state <= ST_LINE;
                    end
                end
                ST_LINE: begin
                    if (w_fv_fall || !r_lv_q) begin
                        r_line_end <= 1'b1;
                        r_line     <= w_line_inc;
                        if (r_col != COL_LAST) r_len_err <= 1'b1;
                        if (w_fv_fall) begin
                            r_state       <= ST_IDLE;
                            r_frame_end   <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                            if ((w_line_inc != LINE_SAT) || r_extra_line ||
                                (r_line == LINE_SAT)) r_cnt_err <= 1'b1;
                        end else begin
                            r_state <= ST_FRAME;
                            if (r_line == LINE_SAT) r_extra_line <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_SYNC;
            endcase
        end
    end

    assign VALID_DATA     = r_valid;
    assign DATA_OUT       = r_data;
    assign CURRENT_COLUMN = r_cur_col;
    assign CURRENT_LINE   = r_cur_line;
    assign FRAME_START    = r_frame_start;
    assign LINE_END       = r_line_end;
    assign FRAME_END      = r_frame_end;
    assign FRAME_COUNT    = r_frame_count;
    assign LINE_LEN_ERR   = r_len_err;
    assign LINE_CNT_ERR   = r_cnt_err;

endmodule
